// File: rtl/br_resolve_ctrl_if.sv
// rtl/br_resolve_ctrl_if.sv - branch resolution driver bus: dispatch, execute resolve, stack/flush outputs
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

interface br_resolve_if;
  logic                   disp_br_i;
  logic [`BR_MASK_W-1:0]  br_mask_i;
  logic                   full_i;
  logic                   ex_valid_i;
  logic [`BR_MASK_W-1:0]  ex_bit_i;
  logic                   ex_mispred_i;
  logic [`BR_STATE_W-1:0] br_state_o;
  logic [`BR_MASK_W-1:0]  br_dep_mask_o;
  logic                   disp_stall_o;
  logic [`BR_MASK_W-1:0]  squash_mask_o;

  modport master (
    output disp_br_i, br_mask_i, full_i, ex_valid_i, ex_bit_i, ex_mispred_i,
    input  br_state_o, br_dep_mask_o, disp_stall_o, squash_mask_o
  );

  modport slave (
    input  disp_br_i, br_mask_i, full_i, ex_valid_i, ex_bit_i, ex_mispred_i,
    output br_state_o, br_dep_mask_o, disp_stall_o, squash_mask_o
  );
endinterface

// File: rtl/br_resolve_ctrl.sv
// rtl/br_resolve_ctrl.sv - tracks in-flight branch tags, orders resolutions, squashes and stalls on mispredict
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module br_resolve_ctrl #(
  parameter int RC_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  br_resolve_if.slave bus
);
  localparam int W = `BR_MASK_W;

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [W-1:0] valid, pend_c, pend_w;
  logic [W-1:0] dep [W];

  logic [W-1:0] wr_sel, cr_sel, iss_sel, sel_dep, squash, clr;
  logic [W-1:0] m, new_sel, res_hit;
  logic         issue_wrong, issue_correct, stall, disp_ok;
  logic [W-1:0] valid_n, pend_c_n, pend_w_n;
  logic [W-1:0] dep_n [W];

  // Issue selection: oldest mispredict first, else lowest-index correct; squash set for a wrong issue
  always_comb begin
    wr_sel = '0;
    cr_sel = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (pend_w[k] && ((dep[k] & pend_w) == '0)) wr_sel = W'(1) << k;
      if (pend_c[k]) cr_sel = W'(1) << k;
    end
    issue_wrong   = (state == IDLE) && (pend_w != '0);
    issue_correct = (state == IDLE) && (pend_w == '0) && (pend_c != '0);
    iss_sel = issue_wrong ? wr_sel : (issue_correct ? cr_sel : '0);
    sel_dep = '0;
    squash  = '0;
    for (int k = 0; k < W; k++) begin
      if (iss_sel[k]) sel_dep = sel_dep | dep[k];
      if (issue_wrong && valid[k] && ((dep[k] & wr_sel) != '0)) squash[k] = 1'b1;
    end
    if (issue_wrong) squash = squash | wr_sel;
    stall = (state == RECOVER) || issue_wrong;
  end

  assign bus.br_state_o    = issue_wrong ? `BR_PR_WRONG : (issue_correct ? `BR_PR_CORRECT : `BR_NONE);
  assign bus.br_dep_mask_o = (issue_wrong || issue_correct) ? (sel_dep | iss_sel) : '0;
  assign bus.disp_stall_o  = stall;
  assign bus.squash_mask_o = squash;

  // Next tag state: retire/squash first, then capture resolutions on survivors, then allocate the new tag
  always_comb begin
    clr = issue_wrong ? squash : (issue_correct ? cr_sel : '0);
    valid_n  = valid & ~clr;
    pend_c_n = pend_c & ~clr;
    pend_w_n = pend_w & ~clr;
    for (int i = 0; i < W; i++) dep_n[i] = clr[i] ? '0 : (dep[i] & ~clr);

    res_hit = bus.ex_valid_i ? (bus.ex_bit_i & valid_n) : '0;
    if (bus.ex_mispred_i) pend_w_n = pend_w_n | res_hit;
    else                  pend_c_n = pend_c_n | res_hit;

    // The tag freed by a CORRECT issue this cycle is immediately reusable
    m = bus.br_mask_i & ~(issue_correct ? cr_sel : '0);
    new_sel = '0;
    for (int k = W - 1; k >= 0; k--) if (!m[k]) new_sel = W'(1) << k;
    disp_ok = bus.disp_br_i && !bus.full_i && !stall && (new_sel != '0);
    if (disp_ok) begin
      valid_n  = valid_n | new_sel;
      pend_c_n = pend_c_n & ~new_sel;
      pend_w_n = pend_w_n & ~new_sel;
      for (int i = 0; i < W; i++) if (new_sel[i]) dep_n[i] = m;
    end
  end

  // State registers and IDLE/RECOVER sequencing after a wrong issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= '0;
      pend_c <= '0;
      pend_w <= '0;
      for (int i = 0; i < W; i++) dep[i] <= '0;
    end else begin
      valid  <= valid_n;
      pend_c <= pend_c_n;
      pend_w <= pend_w_n;
      for (int i = 0; i < W; i++) dep[i] <= dep_n[i];
      case (state)
        IDLE: begin
          if (issue_wrong && (RC_CYCLES > 0)) begin
            state <= RECOVER;
            cnt   <= 2'(RC_CYCLES);
          end
        end
        RECOVER: begin
          if (cnt <= 2'd1) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// tb/tb_br_resolve_ctrl.sv - directed checks of branch resolution ordering, squash, stall and dispatch
module tb_br_resolve_ctrl;
  localparam logic [3:0] NONE = 4'd0;
  localparam logic [3:0] COR  = 4'd1;
  localparam logic [3:0] WRG  = 4'd2;

  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  br_resolve_if bus ();

  br_resolve_ctrl #(.RC_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] st, input logic [3:0] dm,
                      input logic [3:0] stl, input logic [3:0] sq);
    chk({tag, ".state"}, 4'(bus.br_state_o), st);
    chk({tag, ".dep"},   4'(bus.br_dep_mask_o), dm);
    chk({tag, ".stall"}, 4'(bus.disp_stall_o), stl);
    chk({tag, ".squash"}, 4'(bus.squash_mask_o), sq);
  endtask

  task automatic disp(input logic [3:0] mask);
    bus.disp_br_i = 1'b1;
    bus.br_mask_i = mask;
    tick();
    bus.disp_br_i = 1'b0;
    bus.br_mask_i = 4'b0000;
  endtask

  task automatic res(input logic [3:0] b, input logic mis);
    bus.ex_valid_i   = 1'b1;
    bus.ex_bit_i     = b;
    bus.ex_mispred_i = mis;
    tick();
    bus.ex_valid_i   = 1'b0;
    bus.ex_bit_i     = 4'b0000;
    bus.ex_mispred_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.disp_br_i = 1'b0;
    bus.br_mask_i = 4'b0000;
    bus.full_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    bus.ex_bit_i = 4'b0000;
    bus.ex_mispred_i = 1'b0;
    tick();
    tick();
    outs("reset", NONE, 4'b0000, 4'd0, 4'b0000);
    rst = 1'b0;

    // three dispatches -> tags 0,1,2 with dep 0000,0001,0011
    disp(4'b0000);
    outs("disp0", NONE, 4'b0000, 4'd0, 4'b0000);
    disp(4'b0001);
    disp(4'b0011);
    outs("disp2", NONE, 4'b0000, 4'd0, 4'b0000);

    res(4'b0010, 1'b0);
    outs("cor1", COR, 4'b0011, 4'd0, 4'b0000);
    tick();
    outs("idle1", NONE, 4'b0000, 4'd0, 4'b0000);
    // dep[2] lost bit 1 -> 0001 | 0100
    res(4'b0100, 1'b0);
    outs("cor2", COR, 4'b0101, 4'd0, 4'b0000);
    tick();

    // tag0 alone valid; new branch gets tag1 with dep 0001
    disp(4'b0001);
    res(4'b0001, 1'b0);
    outs("cor0", COR, 4'b0001, 4'd0, 4'b0000);
    // dispatch alongside the CORRECT of tag0: m = 0010 -> tag0 reused
    bus.disp_br_i = 1'b1;
    bus.br_mask_i = 4'b0011;
    tick();
    bus.disp_br_i = 1'b0;
    bus.br_mask_i = 4'b0000;
    outs("reuse", NONE, 4'b0000, 4'd0, 4'b0000);
    res(4'b0001, 1'b0);
    outs("cor0b", COR, 4'b0011, 4'd0, 4'b0000);
    tick();
    res(4'b0010, 1'b0);
    outs("cor1b", COR, 4'b0010, 4'd0, 4'b0000);
    tick();

    // tag2 wrong then tag0 wrong one cycle later
    do_reset();
    disp(4'b0000);
    disp(4'b0001);
    disp(4'b0011);
    res(4'b0100, 1'b1);
    outs("wr2", WRG, 4'b0111, 4'd1, 4'b0100);
    res(4'b0001, 1'b1);
    outs("rec_a", NONE, 4'b0000, 4'd1, 4'b0000);
    tick();
    outs("wr0", WRG, 4'b0001, 4'd1, 4'b0011);
    tick();
    outs("rec_b", NONE, 4'b0000, 4'd1, 4'b0000);
    tick();
    outs("after_b", NONE, 4'b0000, 4'd0, 4'b0000);

    // pending correct on tag1 with pending wrong on older tag0
    do_reset();
    disp(4'b0000);
    disp(4'b0001);
    disp(4'b0011);
    res(4'b0100, 1'b1);
    outs("wr2c", WRG, 4'b0111, 4'd1, 4'b0100);
    res(4'b0010, 1'b0);
    outs("rec_c", NONE, 4'b0000, 4'd1, 4'b0000);
    res(4'b0001, 1'b1);
    outs("wr0c", WRG, 4'b0001, 4'd1, 4'b0011);
    tick();
    outs("rec_c2", NONE, 4'b0000, 4'd1, 4'b0000);
    tick();
    outs("nocor1", NONE, 4'b0000, 4'd0, 4'b0000);
    tick();
    outs("nocor1b", NONE, 4'b0000, 4'd0, 4'b0000);

    // full stack: dispatch ignored, so a resolve of tag0 is dropped
    bus.full_i = 1'b1;
    disp(4'b0000);
    bus.full_i = 1'b0;
    res(4'b0001, 1'b0);
    outs("full", NONE, 4'b0000, 4'd0, 4'b0000);
    disp(4'b0000);
    res(4'b0001, 1'b0);
    outs("cor_nf", COR, 4'b0001, 4'd0, 4'b0000);
    tick();

    // reset in the middle of RECOVER
    disp(4'b0000);
    res(4'b0001, 1'b1);
    outs("wr_e", WRG, 4'b0001, 4'd1, 4'b0001);
    tick();
    outs("rec_e", NONE, 4'b0000, 4'd1, 4'b0000);
    rst = 1'b1;
    tick();
    outs("rst_rec", NONE, 4'b0000, 4'd0, 4'b0000);
    rst = 1'b0;
    tick();
    outs("post_rst", NONE, 4'b0000, 4'd0, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
